// File: rtl/vote_result_reader_pkg.sv
// Shared constants for the vote result reader slice.
//   CNT_W    : width of each candidate tally and of the LED bus
//   NUM_CAND : number of candidates (fixed at 4)
//   ST_*     : FSM state encodings
package vote_pkg;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NUM_CAND = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/vote_result_reader_if.sv
// Bus between the vote logger / board controls and the result reader.
//   mode                  : 0 = voting, 1 = result
//   candN_vote_recvd      : live tally for candidate N
//   candN_button          : display-select pulse for candidate N
//   leds                  : displayed count
//   winner, tie           : scan result (winner 0 = cand1 .. 3 = cand4)
//   result_valid          : leds/winner/tie valid
// master drives the inputs and observes results; slave is the reader.
interface vote_result_reader_if;
  import vote_pkg::*;

  logic             mode;
  logic [CNT_W-1:0] cand1_vote_recvd;
  logic [CNT_W-1:0] cand2_vote_recvd;
  logic [CNT_W-1:0] cand3_vote_recvd;
  logic [CNT_W-1:0] cand4_vote_recvd;
  logic             cand1_button;
  logic             cand2_button;
  logic             cand3_button;
  logic             cand4_button;
  logic [CNT_W-1:0] leds;
  logic [1:0]       winner;
  logic             tie;
  logic             result_valid;

  modport master (
    output mode,
    output cand1_vote_recvd, cand2_vote_recvd, cand3_vote_recvd, cand4_vote_recvd,
    output cand1_button, cand2_button, cand3_button, cand4_button,
    input  leds, winner, tie, result_valid
  );

  modport slave (
    input  mode,
    input  cand1_vote_recvd, cand2_vote_recvd, cand3_vote_recvd, cand4_vote_recvd,
    input  cand1_button, cand2_button, cand3_button, cand4_button,
    output leds, winner, tie, result_valid
  );
endinterface

// File: rtl/vote_result_reader_max_step.sv
// One combinational step of the serial max scan.
//   i_best/i_best_idx/i_tie : running maximum, its index, tie flag
//   i_cand/i_cand_idx       : candidate value under comparison and its index
//   o_best/o_best_idx/o_tie : updated running state
// Equal values set the tie flag but keep the earlier (lower) index.
module vote_max_step
  import vote_pkg::*;
(
  input  logic [CNT_W-1:0] i_best,
  input  logic [1:0]       i_best_idx,
  input  logic             i_tie,
  input  logic [CNT_W-1:0] i_cand,
  input  logic [1:0]       i_cand_idx,
  output logic [CNT_W-1:0] o_best,
  output logic [1:0]       o_best_idx,
  output logic             o_tie
);
  always_comb begin
    o_best     = i_best;
    o_best_idx = i_best_idx;
    o_tie      = i_tie;
    if (i_cand > i_best) begin
      o_best     = i_cand;
      o_best_idx = i_cand_idx;
      o_tie      = 1'b0;
    end else if (i_cand == i_best) begin
      o_tie = 1'b1;
    end
  end
endmodule

// File: rtl/vote_result_reader.sv
// Result-mode reader: on entry to result mode snapshots the four tallies,
// scans them serially (one compare per clock) for winner and tie, then lets
// the candidate buttons select which snapshotted count drives the LEDs.
//   clock  : system clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : vote_result_reader_if.slave (mode, tallies, buttons, results)
module vote_result_reader
  import vote_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  vote_result_reader_if.slave  bus
);
  logic [1:0]       r_state;
  logic             r_mode_q;
  logic [CNT_W-1:0] r_snap [NUM_CAND];
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_best;
  logic [1:0]       r_winner;
  logic             r_tie;
  logic [CNT_W-1:0] r_leds;
  logic             r_valid;

  logic [CNT_W-1:0] w_best;
  logic [1:0]       w_winner;
  logic             w_tie;
  logic             w_btn_hit;
  logic [CNT_W-1:0] w_btn_val;

  vote_max_step u_step (
    .i_best     (r_best),
    .i_best_idx (r_winner),
    .i_tie      (r_tie),
    .i_cand     (r_snap[r_idx]),
    .i_cand_idx (r_idx),
    .o_best     (w_best),
    .o_best_idx (w_winner),
    .o_tie      (w_tie)
  );

  // Lowest-numbered pressed button wins.
  always_comb begin
    w_btn_hit = 1'b1;
    w_btn_val = r_leds;
    if (bus.cand1_button)      w_btn_val = r_snap[0];
    else if (bus.cand2_button) w_btn_val = r_snap[1];
    else if (bus.cand3_button) w_btn_val = r_snap[2];
    else if (bus.cand4_button) w_btn_val = r_snap[3];
    else                       w_btn_hit = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mode_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CAND; i++) r_snap[i] <= '0;
      r_idx    <= '0;
      r_best   <= '0;
      r_winner <= '0;
      r_tie    <= 1'b0;
      r_leds   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_mode_q <= bus.mode;
      // Leaving result mode aborts anything in progress from any state.
      if (!bus.mode) begin
        r_state  <= ST_IDLE;
        r_idx    <= '0;
        r_best   <= '0;
        r_winner <= '0;
        r_tie    <= 1'b0;
        r_leds   <= '0;
        r_valid  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!r_mode_q) begin
              r_snap[0] <= bus.cand1_vote_recvd;
              r_snap[1] <= bus.cand2_vote_recvd;
              r_snap[2] <= bus.cand3_vote_recvd;
              r_snap[3] <= bus.cand4_vote_recvd;
              r_best    <= bus.cand1_vote_recvd;
              r_winner  <= '0;
              r_tie     <= 1'b0;
              r_idx     <= 2'd1;
              r_state   <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            r_best   <= w_best;
            r_winner <= w_winner;
            r_tie    <= w_tie;
            r_idx    <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_leds  <= w_best;
            end
          end
          ST_DONE: begin
            if (w_btn_hit) r_leds <= w_btn_val;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.leds         = r_leds;
  assign bus.winner       = r_winner;
  assign bus.tie          = r_tie;
  assign bus.result_valid = r_valid;
endmodule
